// File: rtl/sample_gain.sv
// -----------------------------------------------------------------------------
// sample_gain
//
// Stereo master-volume stage sitting between the sample source and the S/PDIF
// sink. Each signed 16-bit left/right sample is scaled by a 7-bit volume that
// is set over MIDI CC7. CC120 and CC123 mute the output. A single shared
// 17x9 signed multiplier is time-multiplexed between the two channels by a
// four-state FSM (IDLE -> LOAD -> MUL -> EMIT).
//
// Optional feature macro: SAMPLE_GAIN_RAMP_EN
//   defined   : applied volume walks +/-1 toward the target once per
//               right-channel EMIT, which removes zipper noise; mute stays
//               immediate.
//   undefined : applied volume follows the target on the cycle after the CC.
//
// Ports
//   clk              in   system clock
//   reset_n          in   synchronous active-low reset
//   midi_rdy         in   one-cycle strobe, midi_* fields valid
//   midi_cmd         in   decoded MIDI command (CC when == `MIDI_CMD_CC)
//   midi_ch_sysn     in   MIDI channel
//   midi_data0       in   CC number
//   midi_data1       in   CC value
//   left_sample_rdy  in   one-cycle strobe, left_sample_in valid
//   left_sample_in   in   signed left sample
//   right_sample_rdy in   one-cycle strobe, right_sample_in valid
//   right_sample_in  in   signed right sample
//   left_sample_stb  out  one-cycle strobe, left_sample_out valid
//   left_sample_out  out  scaled left sample, held until the next left strobe
//   right_sample_stb out  one-cycle strobe, right_sample_out valid
//   right_sample_out out  scaled right sample, held until the next right strobe
//   overrun          out  sticky: a channel strobed while still pending
// -----------------------------------------------------------------------------

`ifndef MIDI_CMD_SIZE
`define MIDI_CMD_SIZE 3
`endif
`ifndef MIDI_CMD_CC
`define MIDI_CMD_CC 3'd3
`endif

module sample_gain #(
    parameter logic [3:0] MIDI_CH     = 4'd0,
    parameter logic [6:0] DEFAULT_VOL = 7'd100
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      midi_rdy,
    input  logic [`MIDI_CMD_SIZE-1:0] midi_cmd,
    input  logic [3:0]                midi_ch_sysn,
    input  logic [6:0]                midi_data0,
    input  logic [6:0]                midi_data1,
    input  logic                      left_sample_rdy,
    input  logic [15:0]               left_sample_in,
    input  logic                      right_sample_rdy,
    input  logic [15:0]               right_sample_in,
    output logic                      left_sample_stb,
    output logic [15:0]               left_sample_out,
    output logic                      right_sample_stb,
    output logic [15:0]               right_sample_out,
    output logic                      overrun
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MUL,
        ST_EMIT
    } state_t;

    state_t state_q, state_d;

    logic [15:0]        left_hold_q,  left_hold_d;
    logic [15:0]        right_hold_q, right_hold_d;
    logic               left_pend_q,  left_pend_d;
    logic               right_pend_q, right_pend_d;
    logic               overrun_q,    overrun_d;
    logic [6:0]         target_q,     target_d;
    logic [6:0]         applied_q,    applied_d;
    logic               mute_q,       mute_d;
    logic               chan_q,       chan_d;
    logic [15:0]        operand_q,    operand_d;
    logic [6:0]         gain_q,       gain_d;
    logic               bypass_q,     bypass_d;
    logic signed [24:0] product_q,    product_d;
    logic [15:0]        left_out_q,   left_out_d;
    logic [15:0]        right_out_q,  right_out_d;
    logic               left_stb_q,   left_stb_d;
    logic               right_stb_q,  right_stb_d;

    logic               cc_hit;
    logic               sel_right;
    logic signed [16:0] op_ext;
    logic signed [8:0]  gain_ext;
    logic [15:0]        scaled;
    logic               unused_product_bits;

    // Operands for the shared multiplier: the sample is sign-extended to 17
    // bits and the unsigned gain is zero-extended to a positive 9-bit value.
    assign op_ext   = {operand_q[15], operand_q};
    assign gain_ext = {2'b00, gain_q};

    // Gain never exceeds 126 on the multiply path, so product[22:7] already
    // holds the full-range result; 127 takes the exact bypass path instead.
    assign scaled = bypass_q ? operand_q : product_q[22:7];

    assign unused_product_bits = ^{product_q[24:23], product_q[6:0]};

    assign cc_hit = midi_rdy && (midi_cmd == `MIDI_CMD_CC) && (midi_ch_sysn == MIDI_CH);

    // Left channel wins whenever both are waiting.
    assign sel_right = !left_pend_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Looking at the *_d pending flags lets a fresh strobe
    // start the pipeline on the same edge that captures it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (left_pend_d || right_pend_d) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_MUL;
            ST_MUL:  state_d = ST_EMIT;
            ST_EMIT: state_d = (left_pend_d || right_pend_d) ? ST_LOAD : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        left_hold_d  = left_hold_q;
        right_hold_d = right_hold_q;
        left_pend_d  = left_pend_q;
        right_pend_d = right_pend_q;
        overrun_d    = overrun_q;
        target_d     = target_q;
        mute_d       = mute_q;
        chan_d       = chan_q;
        operand_d    = operand_q;
        gain_d       = gain_q;
        bypass_d     = bypass_q;
        product_d    = product_q;
        left_out_d   = left_out_q;
        right_out_d  = right_out_q;
        left_stb_d   = 1'b0;
        right_stb_d  = 1'b0;

        if (cc_hit) begin
            if (midi_data0 == 7'd7) begin
                target_d = midi_data1;
                mute_d   = 1'b0;
            end else if ((midi_data0 == 7'd120) || (midi_data0 == 7'd123)) begin
                mute_d = 1'b1;
            end
        end

`ifdef SAMPLE_GAIN_RAMP_EN
        applied_d = applied_q;
        if ((state_q == ST_EMIT) && chan_q) begin
            if (applied_q < target_q) begin
                applied_d = applied_q + 7'd1;
            end else if (applied_q > target_q) begin
                applied_d = applied_q - 7'd1;
            end
        end
`else
        applied_d = target_d;
`endif

        // The selected channel's pending flag is cleared in LOAD; a strobe
        // landing in that same cycle re-arms it, so the clear comes first.
        if ((state_q == ST_LOAD) && !sel_right) left_pend_d  = 1'b0;
        if ((state_q == ST_LOAD) &&  sel_right) right_pend_d = 1'b0;

        if (left_sample_rdy) begin
            left_hold_d = left_sample_in;
            left_pend_d = 1'b1;
            if (left_pend_q) overrun_d = 1'b1;
        end
        if (right_sample_rdy) begin
            right_hold_d = right_sample_in;
            right_pend_d = 1'b1;
            if (right_pend_q) overrun_d = 1'b1;
        end

        case (state_q)
            ST_LOAD: begin
                // Gain is frozen here so a CC mid-sample cannot affect it.
                chan_d    = sel_right;
                operand_d = sel_right ? right_hold_q : left_hold_q;
                gain_d    = mute_q ? 7'd0 : applied_q;
                bypass_d  = !mute_q && (applied_q == 7'd127);
            end
            ST_MUL: begin
                product_d = 25'(op_ext) * 25'(gain_ext);
            end
            ST_EMIT: begin
                if (chan_q) begin
                    right_out_d = scaled;
                    right_stb_d = 1'b1;
                end else begin
                    left_out_d = scaled;
                    left_stb_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers. Reset drops any captured or in-flight sample.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            left_hold_q  <= 16'd0;
            right_hold_q <= 16'd0;
            left_pend_q  <= 1'b0;
            right_pend_q <= 1'b0;
            overrun_q    <= 1'b0;
            target_q     <= DEFAULT_VOL;
            applied_q    <= DEFAULT_VOL;
            mute_q       <= 1'b0;
            chan_q       <= 1'b0;
            operand_q    <= 16'd0;
            gain_q       <= 7'd0;
            bypass_q     <= 1'b0;
            product_q    <= 25'sd0;
            left_out_q   <= 16'd0;
            right_out_q  <= 16'd0;
            left_stb_q   <= 1'b0;
            right_stb_q  <= 1'b0;
        end else begin
            left_hold_q  <= left_hold_d;
            right_hold_q <= right_hold_d;
            left_pend_q  <= left_pend_d;
            right_pend_q <= right_pend_d;
            overrun_q    <= overrun_d;
            target_q     <= target_d;
            applied_q    <= applied_d;
            mute_q       <= mute_d;
            chan_q       <= chan_d;
            operand_q    <= operand_d;
            gain_q       <= gain_d;
            bypass_q     <= bypass_d;
            product_q    <= product_d;
            left_out_q   <= left_out_d;
            right_out_q  <= right_out_d;
            left_stb_q   <= left_stb_d;
            right_stb_q  <= right_stb_d;
        end
    end

    assign left_sample_stb  = left_stb_q;
    assign left_sample_out  = left_out_q;
    assign right_sample_stb = right_stb_q;
    assign right_sample_out = right_out_q;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_sample_gain.sv
`ifndef MIDI_CMD_SIZE
`define MIDI_CMD_SIZE 3
`endif
`ifndef MIDI_CMD_CC
`define MIDI_CMD_CC 3'd3
`endif

module tb_sample_gain;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic                      midi_rdy;
    logic [`MIDI_CMD_SIZE-1:0] midi_cmd;
    logic [3:0]                midi_ch_sysn;
    logic [6:0]                midi_data0;
    logic [6:0]                midi_data1;
    logic                      left_sample_rdy;
    logic [15:0]               left_sample_in;
    logic                      right_sample_rdy;
    logic [15:0]               right_sample_in;
    logic                      left_sample_stb;
    logic [15:0]               left_sample_out;
    logic                      right_sample_stb;
    logic [15:0]               right_sample_out;
    logic                      overrun;

    typedef struct {
        logic [15:0] val;
        int          due;
    } exp_t;

    exp_t leftQ[$];
    exp_t rightQ[$];

    int cyc = 0;
    int nVec = 0;
    int nMiss = 0;

    // Reference volume state, updated whenever a CC is driven.
    int mVol = 100;
    bit mMute = 1'b0;

    sample_gain #(.MIDI_CH(4'd0), .DEFAULT_VOL(7'd100)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .midi_rdy         (midi_rdy),
        .midi_cmd         (midi_cmd),
        .midi_ch_sysn     (midi_ch_sysn),
        .midi_data0       (midi_data0),
        .midi_data1       (midi_data1),
        .left_sample_rdy  (left_sample_rdy),
        .left_sample_in   (left_sample_in),
        .right_sample_rdy (right_sample_rdy),
        .right_sample_in  (right_sample_in),
        .left_sample_stb  (left_sample_stb),
        .left_sample_out  (left_sample_out),
        .right_sample_stb (right_sample_stb),
        .right_sample_out (right_sample_out),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        if (obs !== exp) begin
            nMiss++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] modelGain(input logic [15:0] s);
        int p;
        if (mMute) return 16'h0000;
        if (mVol == 127) return s;
        p = int'($signed(s)) * mVol;
        p = p >>> 7;
        return p[15:0];
    endfunction

    // Output monitor: every strobe must match the oldest expected sample.
    always @(negedge clk) begin
        exp_t e;
        if (left_sample_stb) begin
            if (leftQ.size() == 0) begin
                checkOutput("left_unexpected_stb", 32'd1, 32'd0);
            end else begin
                e = leftQ.pop_front();
                checkOutput("left_value", {16'd0, left_sample_out}, {16'd0, e.val});
                if (e.due >= 0) checkOutput("left_latency", cyc, e.due);
            end
        end
        if (right_sample_stb) begin
            if (rightQ.size() == 0) begin
                checkOutput("right_unexpected_stb", 32'd1, 32'd0);
            end else begin
                e = rightQ.pop_front();
                checkOutput("right_value", {16'd0, right_sample_out}, {16'd0, e.val});
                if (e.due >= 0) checkOutput("right_latency", cyc, e.due);
            end
        end
    end

    // Drive one cycle of sample strobes and queue the expected outputs.
    task automatic applyStimulus(input bit lRdy, input logic [15:0] lVal,
                                 input bit rRdy, input logic [15:0] rVal,
                                 input bit timed);
        exp_t e;
        @(negedge clk);
        left_sample_rdy  = lRdy;
        left_sample_in   = lVal;
        right_sample_rdy = rRdy;
        right_sample_in  = rVal;
        if (lRdy) begin
            e.val = modelGain(lVal);
            e.due = timed ? cyc + 4 : -1;
            leftQ.push_back(e);
        end
        if (rRdy) begin
            e.val = modelGain(rVal);
            e.due = timed ? (lRdy ? cyc + 7 : cyc + 4) : -1;
            rightQ.push_back(e);
        end
        @(negedge clk);
        left_sample_rdy  = 1'b0;
        right_sample_rdy = 1'b0;
    endtask

    task automatic sendCc(input logic [`MIDI_CMD_SIZE-1:0] cmd, input logic [3:0] ch,
                          input logic [6:0] d0, input logic [6:0] d1);
        @(negedge clk);
        midi_rdy     = 1'b1;
        midi_cmd     = cmd;
        midi_ch_sysn = ch;
        midi_data0   = d0;
        midi_data1   = d1;
        if ((cmd == `MIDI_CMD_CC) && (ch == 4'd0)) begin
            if (d0 == 7'd7) begin
                mVol  = int'(d1);
                mMute = 1'b0;
            end else if ((d0 == 7'd120) || (d0 == 7'd123)) begin
                mMute = 1'b1;
            end
        end
        @(negedge clk);
        midi_rdy = 1'b0;
    endtask

    task automatic waitIdle();
        int budget;
        budget = 0;
        while (((leftQ.size() != 0) || (rightQ.size() != 0)) && (budget < 60)) begin
            @(negedge clk);
            budget++;
        end
        if ((leftQ.size() != 0) || (rightQ.size() != 0)) begin
            checkOutput("drain_timeout", leftQ.size() + rightQ.size(), 32'd0);
            leftQ.delete();
            rightQ.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset_n          = 1'b0;
        midi_rdy         = 1'b0;
        midi_cmd         = '0;
        midi_ch_sysn     = 4'd0;
        midi_data0       = 7'd0;
        midi_data1       = 7'd0;
        left_sample_rdy  = 1'b0;
        left_sample_in   = 16'd0;
        right_sample_rdy = 1'b0;
        right_sample_in  = 16'd0;

        repeat (3) @(negedge clk);
        checkOutput("rst_left_out",  {16'd0, left_sample_out},  32'd0);
        checkOutput("rst_right_out", {16'd0, right_sample_out}, 32'd0);
        checkOutput("rst_strobes",   {30'd0, left_sample_stb, right_sample_stb}, 32'd0);
        checkOutput("rst_overrun",   {31'd0, overrun}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] default volume 100");
        applyStimulus(1'b1, 16'h4000, 1'b0, 16'h0000, 1'b1);
        waitIdle();

        $display("[TB] unity bypass, simultaneous left and right");
        sendCc(`MIDI_CMD_CC, 4'd0, 7'd7, 7'd127);
        applyStimulus(1'b1, 16'h8000, 1'b1, 16'h7FFF, 1'b1);
        waitIdle();

        $display("[TB] half volume, floor rounding");
        sendCc(`MIDI_CMD_CC, 4'd0, 7'd7, 7'd64);
        applyStimulus(1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b1);
        waitIdle();
        applyStimulus(1'b1, 16'h0100, 1'b1, 16'h8000, 1'b1);
        waitIdle();

        $display("[TB] random volumes and samples");
        for (int i = 0; i < 8; i++) begin
            sendCc(`MIDI_CMD_CC, 4'd0, 7'd7, 7'($urandom_range(0, 127)));
            applyStimulus(1'b1, 16'($urandom), 1'b1, 16'($urandom), 1'b1);
            waitIdle();
        end

        $display("[TB] mute and channel filtering");
        sendCc(`MIDI_CMD_CC, 4'd0, 7'd7, 7'd100);
        sendCc(`MIDI_CMD_CC, 4'd0, 7'd120, 7'd0);
        applyStimulus(1'b1, 16'h1234, 1'b1, 16'h8000, 1'b1);
        waitIdle();
        sendCc(`MIDI_CMD_CC, 4'd5, 7'd7, 7'd50);
        applyStimulus(1'b1, 16'h4000, 1'b0, 16'h0000, 1'b1);
        waitIdle();
        sendCc(`MIDI_CMD_CC, 4'd0, 7'd7, 7'd100);
        applyStimulus(1'b1, 16'h4000, 1'b1, 16'hC000, 1'b1);
        waitIdle();
        sendCc(`MIDI_CMD_CC, 4'd5, 7'd7, 7'd10);
        sendCc(`MIDI_CMD_CC ^ 1, 4'd0, 7'd7, 7'd10);
        applyStimulus(1'b1, 16'h4000, 1'b0, 16'h0000, 1'b1);
        waitIdle();
        sendCc(`MIDI_CMD_CC, 4'd0, 7'd123, 7'd0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'h7FFF, 1'b1);
        waitIdle();
        sendCc(`MIDI_CMD_CC, 4'd0, 7'd7, 7'd100);

        $display("[TB] overrun, latest sample wins");
        checkOutput("overrun_before", {31'd0, overrun}, 32'd0);
        begin
            exp_t e;
            @(negedge clk);
            right_sample_rdy = 1'b1;
            right_sample_in  = 16'h1000;
            e.val = modelGain(16'h1000);
            e.due = cyc + 4;
            rightQ.push_back(e);
            @(negedge clk);
            right_sample_rdy = 1'b0;
            left_sample_rdy  = 1'b1;
            left_sample_in   = 16'h1111;
            @(negedge clk);
            left_sample_in   = 16'h2222;
            e.val = modelGain(16'h2222);
            e.due = -1;
            leftQ.push_back(e);
            @(negedge clk);
            left_sample_rdy  = 1'b0;
        end
        waitIdle();
        checkOutput("overrun_after", {31'd0, overrun}, 32'd1);

        $display("[TB] reset while multiplying");
        @(negedge clk);
        left_sample_rdy = 1'b1;
        left_sample_in  = 16'h4000;
        @(negedge clk);
        left_sample_rdy = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midrst_left_out", {16'd0, left_sample_out}, 32'd0);
        checkOutput("midrst_overrun",  {31'd0, overrun}, 32'd0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("midrst_no_stb", {30'd0, left_sample_stb, right_sample_stb}, 32'd0);

        applyStimulus(1'b1, 16'h4000, 1'b0, 16'h0000, 1'b1);
        waitIdle();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
